// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared constants, types and helpers for the keypad matrix
//            scanner: default geometry/timing parameters, the diff-walk
//            state encoding and the event word layout {release, code}.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 6;
  localparam int DEF_SCAN_DIV   = 8;
  localparam int DEF_DEBOUNCE   = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  // Width of a key index; a 1-key matrix still needs a 1-bit code.
  function automatic int code_width(input int n_keys);
    return (n_keys <= 1) ? 1 : $clog2(n_keys);
  endfunction

  // Event word: release flag in the MSB, key code below it.
  function automatic int evt_width(input int n_keys);
    return code_width(n_keys) + 1;
  endfunction

  typedef enum logic [0:0] {
    WALK_IDLE = 1'b0,
    WALK_RUN  = 1'b1
  } walk_state_e;

endpackage
`default_nettype wire

// File: rtl/keypad_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keypad_evt_fifo
// Purpose  : Synchronous first-word-fall-through FIFO for key events.
//            A write into a full FIFO is accepted only when a read happens
//            in the same cycle.
// Ports    : clk, rst_n (async active-low)
//            wr_en, wr_data, full   - write side
//            rd_en, rd_data, empty  - read side; rd_data valid when !empty
// Revision : 1.0 - initial release
// ============================================================================
module keypad_evt_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage is reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_matrix_scanner
// Purpose  : Scans a ROWS x COLS keypad one row at a time (one-cold, active
//            low), debounces whole-frame snapshots and emits one press or
//            release event per committed key change through an event FIFO.
// Ports    : clk, rst_n (async active-low)
//            key_in[COLS]   column sense, active low
//            key_out[ROWS]  row drive, one-cold active low
//            evt_valid/evt_ready/evt_code/evt_release - event stream
//            overflow (sticky drop flag), ovf_clr (sync clear)
// Revision : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,   // >= COLS and >= 2
  parameter int DEBOUNCE   = DEF_DEBOUNCE,   // >= 1
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH  // power of two
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [COLS-1:0]                     key_in,
  output logic [ROWS-1:0]                     key_out,
  output logic                                evt_valid,
  input  logic                                evt_ready,
  output logic [code_width(ROWS*COLS)-1:0]    evt_code,
  output logic                                evt_release,
  output logic                                overflow,
  input  logic                                ovf_clr
);

  localparam int N  = ROWS * COLS;
  localparam int CW = code_width(N);
  localparam int EW = evt_width(N);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int RW = code_width(ROWS);
  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] IDX_LAST  = CW'(N - 1);
  localparam logic [DW-1:0] DEB_C     = DW'(DEBOUNCE);

  logic [SW-1:0]   slot;
  logic [RW-1:0]   row;
  logic [COLS-1:0] sync1;
  logic [COLS-1:0] sync2;
  logic [N-1:0]    frame;
  logic [N-1:0]    prev;
  logic [N-1:0]    committed;
  logic [DW-1:0]   stable_cnt;
  logic [CW-1:0]   idx;
  walk_state_e     state;
  walk_state_e     state_next;

  logic            slot_end;
  logic            frame_end;
  logic [N-1:0]    frame_next;
  logic [DW-1:0]   stable_next;
  logic            start_walk;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_head;

  assign key_out   = ~(ROWS'(1) << row);
  assign slot_end  = (slot == SLOT_LAST);
  assign frame_end = slot_end && (row == ROW_LAST);

  // The last row's sample lands in the same cycle the frame is judged, so
  // the debouncer looks at the bitmap with the current row already merged.
  always_comb begin
    frame_next = frame;
    frame_next[int'(row)*COLS +: COLS] = ~sync2;
  end

  always_comb begin
    stable_next = DW'(1);
    if (frame_next == prev)
      stable_next = (stable_cnt == DEB_C) ? stable_cnt : stable_cnt + DW'(1);
  end

  // prev always equals frame_next after a frame end, so that is the value
  // the walk will compare against committed.
  assign start_walk = frame_end && (stable_next == DEB_C) &&
                      (frame_next != committed);

  // Scan timing and row sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot  <= '0;
      row   <= '0;
      sync1 <= '1;
      sync2 <= '1;
      frame <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      if (slot_end) begin
        slot  <= '0;
        frame <= frame_next;
        row   <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  // Frame-level debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      stable_cnt <= '0;
    end else if (frame_end) begin
      prev       <= frame_next;
      stable_cnt <= stable_next;
    end
  end

  // Diff-walk state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WALK_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      WALK_IDLE: if (start_walk) state_next = WALK_RUN;
      WALK_RUN: begin
        push = (prev[idx] != committed[idx]);
        if (idx == IDX_LAST) state_next = WALK_IDLE;
      end
      default: state_next = WALK_IDLE;
    endcase
  end

  // Walk index and committed bitmap; committed follows prev even when the
  // event itself is dropped, so a later release still reports correctly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      committed <= '0;
    end else begin
      idx <= (state == WALK_RUN) ? idx + CW'(1) : '0;
      if (push) committed[idx] <= prev[idx];
    end
  end

  assign pop = evt_valid && evt_ready;

  // Set wins over clear; a push into a full FIFO survives if a pop frees
  // the slot in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          overflow <= 1'b0;
    else if (push && fifo_full && !pop)  overflow <= 1'b1;
    else if (ovf_clr)                    overflow <= 1'b0;
  end

  keypad_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data ({~prev[idx], idx}),
    .full    (fifo_full),
    .rd_en   (evt_ready),
    .rd_data (fifo_head),
    .empty   (fifo_empty)
  );

  assign evt_valid   = !fifo_empty;
  assign evt_release = fifo_head[EW-1];
  assign evt_code    = fifo_head[CW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_matrix_scanner
// Purpose  : Directed bench for keypad_matrix_scanner at default parameters.
//            A keypad model turns a "pressed" bitmap into column levels for
//            the currently driven row; expected events go into a queue that
//            a monitor drains whenever the DUT hands over an event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 6;
  localparam int N     = ROWS * COLS;
  localparam int CW    = 5;
  localparam int FRAME = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [COLS-1:0] key_in;
  logic [ROWS-1:0] key_out;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [CW-1:0] evt_code;
  logic          evt_release;
  logic          overflow;
  logic          ovf_clr = 1'b0;
  logic [N-1:0]  pressed = '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CW:0] sb[$];

  always #5 clk = ~clk;

  keypad_matrix_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_out     (key_out),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_release (evt_release),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  // Keypad: a closed key pulls its column low while its row is driven.
  always_comb begin
    key_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!key_out[r] && pressed[r*COLS+c]) key_in[c] = 1'b0;
  end

  // Monitor: every handshake is matched against the head of the queue.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL evt_unexpected: got release=%0d code=%0d, required no event",
                 evt_release, evt_code);
      end else begin
        logic [CW:0] exp_evt;
        exp_evt = sb.pop_front();
        if ({evt_release, evt_code} !== exp_evt) begin
          n_bad++;
          $display("FAIL evt: got release=%0d code=%0d, required release=%0d code=%0d",
                   evt_release, evt_code, exp_evt[CW], exp_evt[CW-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic rel, input int code);
    sb.push_back({rel, CW'(code)});
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_key_out", 32'(key_out), 32'h0000_000E);
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_evt_code", 32'(evt_code), 0);
    check("rst_evt_release", 32'(evt_release), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;

    // Idle scanning: row advances every 8 clocks, cycling 0..3.
    for (int j = 1; j <= 40; j++) begin
      tick(1);
      if (j % 8 == 4) begin
        logic [3:0] exp_row;
        exp_row = ~(4'b0001 << ((j / 8) % 4));
        check("scan_key_out", 32'(key_out), 32'(exp_row));
      end
    end
    tick(9 * FRAME);
    check("idle_evt_valid", 32'(evt_valid), 0);
    check("idle_overflow", 32'(overflow), 0);

    // Single key row 1 / col 2 -> code 8 press then release.
    evt_ready = 1'b1;
    expect_evt(1'b0, 8);
    pressed[8] = 1'b1;
    tick(5 * FRAME);
    check("press8_drain", sb.size(), 0);
    expect_evt(1'b1, 8);
    pressed[8] = 1'b0;
    tick(5 * FRAME);
    check("release8_drain", sb.size(), 0);

    // Bounce: closed for only two frames, never committed.
    pressed[8] = 1'b1;
    tick(2 * FRAME);
    pressed[8] = 1'b0;
    tick(6 * FRAME);
    check("bounce_no_evt", 32'(evt_valid), 0);

    // Two keys in one frame, reported in ascending code order.
    expect_evt(1'b0, 0);
    expect_evt(1'b0, 23);
    pressed[0]  = 1'b1;
    pressed[23] = 1'b1;
    tick(6 * FRAME);
    check("dual_press_drain", sb.size(), 0);
    expect_evt(1'b1, 0);
    expect_evt(1'b1, 23);
    pressed = '0;
    tick(6 * FRAME);
    check("dual_release_drain", sb.size(), 0);

    // Back-pressure: five presses, only the first four fit.
    evt_ready = 1'b0;
    for (int k = 1; k <= 4; k++) expect_evt(1'b0, k);
    pressed[5:1] = 5'b11111;
    tick(6 * FRAME);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_head_valid", 32'(evt_valid), 1);
    check("ovf_head_code", 32'(evt_code), 1);
    tick(5);
    check("ovf_head_stable", 32'(evt_code), 1);
    check("ovf_head_release", 32'(evt_release), 0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clear", 32'(overflow), 0);
    evt_ready = 1'b1;
    tick(10);
    check("ovf_drain", sb.size(), 0);
    check("ovf_empty", 32'(evt_valid), 0);
    // Key 5's event was dropped but its state still committed.
    for (int k = 1; k <= 5; k++) expect_evt(1'b1, k);
    pressed = '0;
    tick(6 * FRAME);
    check("ovf_release_drain", sb.size(), 0);

    // Reset in the middle of a diff walk.
    evt_ready   = 1'b0;
    pressed[0]  = 1'b1;
    pressed[23] = 1'b1;
    begin
      int t;
      t = 0;
      while (!evt_valid && t < 10 * FRAME) begin
        tick(1);
        t++;
      end
    end
    check("walk_started", 32'(evt_valid), 1);
    rst_n = 1'b0;
    #1;
    check("midwalk_rst_valid", 32'(evt_valid), 0);
    tick(3);
    rst_n = 1'b1;
    check("post_rst_key_out", 32'(key_out), 32'h0000_000E);
    check("post_rst_valid", 32'(evt_valid), 0);
    expect_evt(1'b0, 0);
    expect_evt(1'b0, 23);
    evt_ready = 1'b1;
    tick(6 * FRAME);
    check("held_keys_drain", sb.size(), 0);
    expect_evt(1'b1, 0);
    expect_evt(1'b1, 23);
    pressed = '0;
    tick(6 * FRAME);
    check("final_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
